bus_xfer_engine: RTL and testbench

Parametrised successor to the three-register shared-bus datapath. It holds NREG registers of WIDTH bits on one internal bus and runs a command-driven transfer sequencer that replaces the hand-driven enable/load strobes. The bus is a registered-select multiplexer, not a tristate bus, so it can never have two drivers. Supported operations are multi-destination move, external load, register swap through a hidden temp register, and masked clear.

---
 rtl/bus_xfer_pkg.sv | 16 +
 rtl/bus_xfer_engine_regn_en.sv | 17 +
 rtl/bus_xfer_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_bus_xfer_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared op-codes and sequencer state encoding for bus_xfer_engine.
package bus_xfer_pkg;

  localparam logic [1:0] OP_MOVE   = 2'b00;
  localparam logic [1:0] OP_LOADIN = 2'b01;
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EX1  = 2'd1,
    EX2  = 2'd2,
    EX3  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_xfer_engine_regn_en.sv
// WIDTH-bit load-enable register with asynchronous active-high reset.
module regN_en #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/bus_xfer_engine.sv
// Command-driven transfer engine over NREG registers on a registered-select bus.
// Optional per-register even parity with par_err reporting: define BUS_PARITY_EN.
module bus_xfer_engine
  import bus_xfer_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREG  = 4,
  localparam int unsigned IDXW  = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [IDXW-1:0]       cmd_src,
  input  logic [IDXW-1:0]       cmd_dst,
  input  logic [NREG-1:0]       cmd_mask,
  input  logic [WIDTH-1:0]      in_data,
  output logic [NREG*WIDTH-1:0] regs_flat,
  output logic [WIDTH-1:0]      zbus,
  output logic                  busy,
  output logic                  done,
`ifdef BUS_PARITY_EN
  output logic                  par_err,
`endif
  output logic                  err
);

  localparam logic [IDXW:0] NREG_W = (IDXW+1)'(NREG);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [IDXW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              done_q, done_d, err_q, err_d, ready_q, ready_d;

  logic [WIDTH-1:0]  reg_q [NREG];
  logic [WIDTH-1:0]  tmp_q;
  logic [NREG-1:0]   reg_ld;
  logic              tmp_ld;
  logic [WIDTH-1:0]  bus, src_val, dst_val;
  logic              src_bad, dst_bad, cmd_bad;

`ifdef BUS_PARITY_EN
  logic [NREG-1:0]   par_q, par_d;
  logic              par_acc_q, par_acc_d, par_err_q, par_err_d;
  logic              src_par, dst_par, src_mis, dst_mis;
`endif

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    regN_en #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .ld  (reg_ld[g]),
      .d   (bus),
      .q   (reg_q[g])
    );
    assign regs_flat[g*WIDTH +: WIDTH] = reg_q[g];
  end

  regN_en #(.WIDTH(WIDTH)) u_tmp (
    .clk (clk),
    .rst (rst),
    .ld  (tmp_ld),
    .d   (bus),
    .q   (tmp_q)
  );

  // Register read selects driven only by captured command fields.
  always_comb begin
    src_val = '0;
    dst_val = '0;
`ifdef BUS_PARITY_EN
    src_par = 1'b0;
    dst_par = 1'b0;
`endif
    for (int i = 0; i < NREG; i++) begin
      if (src_q == IDXW'(i)) begin
        src_val = reg_q[i];
`ifdef BUS_PARITY_EN
        src_par = par_q[i];
`endif
      end
      if (dst_q == IDXW'(i)) begin
        dst_val = reg_q[i];
`ifdef BUS_PARITY_EN
        dst_par = par_q[i];
`endif
      end
    end
`ifdef BUS_PARITY_EN
    src_mis = (^src_val) != src_par;
    dst_mis = (^dst_val) != dst_par;
`endif
  end

  always_comb begin
    bus = '0;
    case (state_q)
      EX1: begin
        case (op_q)
          OP_MOVE, OP_SWAP: bus = src_val;
          OP_LOADIN:        bus = data_q;
          default:          bus = '0;
        endcase
      end
      EX2:     bus = dst_val;
      EX3:     bus = tmp_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    reg_ld = '0;
    tmp_ld = 1'b0;
    case (state_q)
      EX1: begin
        if (op_q == OP_SWAP) tmp_ld = 1'b1;
        else                 reg_ld = mask_q;
      end
      EX2: for (int i = 0; i < NREG; i++) reg_ld[i] = (src_q == IDXW'(i));
      EX3: for (int i = 0; i < NREG; i++) reg_ld[i] = (dst_q == IDXW'(i));
      default: reg_ld = '0;
    endcase
  end

  // Acceptance-time legality check on the raw command inputs.
  always_comb begin
    src_bad = {1'b0, cmd_src} >= NREG_W;
    dst_bad = {1'b0, cmd_dst} >= NREG_W;
    case (cmd_op)
      OP_MOVE: cmd_bad = src_bad || (cmd_mask == '0);
      OP_SWAP: cmd_bad = src_bad || dst_bad;
      default: cmd_bad = (cmd_mask == '0);
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    mask_d  = mask_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            op_d    = cmd_op;
            src_d   = cmd_src;
            dst_d   = cmd_dst;
            mask_d  = cmd_mask;
            data_d  = in_data;
            state_d = EX1;
          end
        end
      end
      EX1: begin
        if (op_q == OP_SWAP) begin
          state_d = EX2;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      EX2: state_d = EX3;
      EX3: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
`ifdef BUS_PARITY_EN
    par_d = par_q;
    for (int i = 0; i < NREG; i++) begin
      if (reg_ld[i]) par_d[i] = ^bus;
    end
    // Accumulate source mismatches across the operation, report with done.
    case (state_q)
      IDLE:    par_acc_d = 1'b0;
      EX1:     par_acc_d = ((op_q == OP_MOVE) || (op_q == OP_SWAP)) && src_mis;
      EX2:     par_acc_d = par_acc_q | dst_mis;
      default: par_acc_d = par_acc_q;
    endcase
    par_err_d = done_d & par_acc_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_MOVE;
      src_q     <= '0;
      dst_q     <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
`ifdef BUS_PARITY_EN
      par_q     <= '0;
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
`ifdef BUS_PARITY_EN
      par_q     <= par_d;
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = ~ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign zbus      = bus;
`ifdef BUS_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Scoreboard bench for bus_xfer_engine: directed plan items plus randomized commands.
module tb_bus_xfer_engine;
  import bus_xfer_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IX = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cmd_valid, cmd_ready, busy, done, err;
  logic [1:0]       cmd_op;
  logic [IX-1:0]    cmd_src, cmd_dst;
  logic [N-1:0]     cmd_mask;
  logic [W-1:0]     in_data, zbus;
  logic [N*W-1:0]   regs_flat;
`ifdef BUS_PARITY_EN
  logic             par_err, c3_par_err;
`endif

  logic             c3_valid, c3_ready, c3_busy, c3_done, c3_err;
  logic [1:0]       c3_op, c3_src, c3_dst;
  logic [2:0]       c3_mask;
  logic [W-1:0]     c3_data, c3_zbus;
  logic [3*W-1:0]   c3_regs;

  bus_xfer_engine #(.WIDTH(W), .NREG(N)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_mask(cmd_mask),
    .in_data(in_data), .regs_flat(regs_flat), .zbus(zbus), .busy(busy),
    .done(done),
`ifdef BUS_PARITY_EN
    .par_err(par_err),
`endif
    .err(err)
  );

  bus_xfer_engine #(.WIDTH(W), .NREG(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_src(c3_src), .cmd_dst(c3_dst), .cmd_mask(c3_mask),
    .in_data(c3_data), .regs_flat(c3_regs), .zbus(c3_zbus), .busy(c3_busy),
    .done(c3_done),
`ifdef BUS_PARITY_EN
    .par_err(c3_par_err),
`endif
    .err(c3_err)
  );

  typedef struct {
    logic           is_err;
    logic [N*W-1:0] regs;
    int             cyc;
    logic           par;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [W-1:0] m_regs [N];
  bit         m_bad [N];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_bad[i]  = 1'b0;
    end
  endtask

  // Reference semantics: apply the command to the array model and queue the response.
  task automatic issue(input logic [1:0] op, input logic [IX-1:0] s, input logic [IX-1:0] d,
                       input logic [N-1:0] mk, input logic [W-1:0] dat, input bit hold,
                       output int acc);
    int g;
    exp_t e;
    logic [W-1:0] v;
    g   = 0;
    acc = -1;
    @(negedge clk);
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 64'(cmd_ready), 64'(1));
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_mask  = mk;
    in_data   = dat;
    @(posedge clk);
    #1;
    acc      = cyc;
    e.is_err = (op != OP_SWAP) && (mk == '0);
    e.par    = 1'b0;
    e.cyc    = acc;
    if (!e.is_err) begin
      if (op == OP_SWAP) begin
        e.par     = m_bad[s] | m_bad[d];
        v         = m_regs[s];
        m_regs[s] = m_regs[d];
        m_regs[d] = v;
        m_bad[s]  = 1'b0;
        m_bad[d]  = 1'b0;
        e.cyc     = acc + 3;
      end else begin
        v = (op == OP_MOVE) ? m_regs[s] : (op == OP_LOADIN) ? dat : '0;
        if (op == OP_MOVE) e.par = m_bad[s];
        for (int i = 0; i < N; i++) begin
          if (mk[i]) begin
            m_regs[i] = v;
            m_bad[i]  = 1'b0;
          end
        end
        e.cyc = acc + 1;
      end
    end
    e.regs = model_flat();
    sb.push_back(e);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Monitor: every done/err pulse consumes one expected response.
  always @(negedge clk) begin
    if (!rst && (done === 1'b1 || err === 1'b1)) begin
      chk("done_err_exclusive", 64'(done & err), 64'(0));
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: done=%0b err=%0b with nothing pending", done, err);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_is_err", 64'(err), 64'(mon_e.is_err));
        chk("resp_regs", 64'(regs_flat), 64'(mon_e.regs));
        chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("resp_ready", 64'(cmd_ready), 64'(1));
`ifdef BUS_PARITY_EN
        chk("resp_par_err", 64'(par_err), 64'(mon_e.par));
`endif
      end
    end
  end

  task automatic issue3(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                        input logic [2:0] mk, input logic [W-1:0] dat, input bit exp_err,
                        input int lat, input logic [3*W-1:0] exp_regs);
    @(negedge clk);
    chk("n3_ready", 64'(c3_ready), 64'(1));
    c3_valid = 1'b1;
    c3_op    = op;
    c3_src   = s;
    c3_dst   = d;
    c3_mask  = mk;
    c3_data  = dat;
    @(posedge clk);
    #1;
    c3_valid = 1'b0;
    @(negedge clk);
    chk("n3_err", 64'(c3_err), 64'(exp_err));
    if (!exp_err) repeat (lat) @(negedge clk);
    chk("n3_done", 64'(c3_done), 64'(!exp_err));
    chk("n3_regs", 64'(c3_regs), 64'(exp_regs));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, lo, g;
    logic [1:0] rop;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_mask  = '0;
    in_data   = '0;
    c3_valid  = 1'b0;
    c3_op     = '0;
    c3_src    = '0;
    c3_dst    = '0;
    c3_mask   = '0;
    c3_data   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_regs", 64'(regs_flat), 64'(0));
    chk("rst_zbus", 64'(zbus), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b0;

    // LOADIN A5 into reg0/reg2; bus visible during EX1
    issue(OP_LOADIN, 2'd0, 2'd0, 4'b0101, 8'hA5, 1'b0, a1);
    @(negedge clk);
    chk("loadin_zbus", 64'(zbus), 64'(8'hA5));
    chk("loadin_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("loadin_done", 64'(done), 64'(1));

    // MOVE reg0 -> reg1, reg3; ready low for exactly one cycle
    issue(OP_MOVE, 2'd0, 2'd0, 4'b1010, 8'h00, 1'b0, a1);
    lo = 0;
    @(negedge clk);
    while (!cmd_ready && lo < 10) begin
      lo++;
      @(negedge clk);
    end
    chk("move_ready_low", 64'(lo), 64'(1));

    issue(OP_LOADIN, 2'd0, 2'd0, 4'b0010, 8'h3C, 1'b0, a1);
    issue(OP_LOADIN, 2'd0, 2'd0, 4'b0100, 8'hC3, 1'b0, a1);
    issue(OP_SWAP, 2'd1, 2'd2, 4'b0000, 8'h00, 1'b0, a1);
    issue(OP_SWAP, 2'd3, 2'd3, 4'b0000, 8'h00, 1'b0, a1);
    issue(OP_MOVE, 2'd1, 2'd0, 4'b0000, 8'h00, 1'b0, a1);
    issue(OP_LOADIN, 2'd0, 2'd0, 4'b0000, 8'hFF, 1'b0, a1);
    issue(OP_CLEAR, 2'd0, 2'd0, 4'b0000, 8'h00, 1'b0, a1);
    issue(OP_CLEAR, 2'd0, 2'd0, 4'b1001, 8'h00, 1'b0, a1);

    // Reset during SWAP EX2 abandons the operation
    issue(OP_SWAP, 2'd1, 2'd2, 4'b0000, 8'h00, 1'b0, a1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("midrst_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_regs", 64'(regs_flat), 64'(0));
    chk("midrst_zbus", 64'(zbus), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'(0));
    end

    // Back-to-back with cmd_valid held: second accept on the done cycle
    issue(OP_LOADIN, 2'd0, 2'd0, 4'b0001, 8'h5A, 1'b1, a1);
    issue(OP_MOVE, 2'd0, 2'd0, 4'b1110, 8'h00, 1'b0, a2);
    chk("b2b_accept_cycle", 64'(a2), 64'(a1 + 2));

    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      issue(rop, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 8'($urandom),
            (i < 199) ? bit'($urandom_range(0, 1)) : 1'b0, a1);
    end

    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(sb.size()), 64'(0));

    // NREG=3 build: out-of-range indices are rejected
    issue3(OP_LOADIN, 2'd0, 2'd0, 3'b111, 8'h5A, 1'b0, 1, 24'h5A5A5A);
    issue3(OP_LOADIN, 2'd0, 2'd0, 3'b001, 8'h11, 1'b0, 1, 24'h5A5A11);
    issue3(OP_SWAP,   2'd0, 2'd3, 3'b000, 8'h00, 1'b1, 0, 24'h5A5A11);
    issue3(OP_MOVE,   2'd3, 2'd0, 3'b001, 8'h00, 1'b1, 0, 24'h5A5A11);
    issue3(OP_SWAP,   2'd0, 2'd2, 3'b000, 8'h00, 1'b0, 3, 24'h115A5A);

`ifdef BUS_PARITY_EN
    issue(OP_LOADIN, 2'd0, 2'd0, 4'b0100, 8'h77, 1'b0, a1);
    repeat (3) @(negedge clk);
    u_dut.par_q[2] = ~u_dut.par_q[2];
    m_bad[2] = 1'b1;
    issue(OP_MOVE, 2'd2, 2'd0, 4'b0001, 8'h00, 1'b0, a1);
    issue(OP_MOVE, 2'd0, 2'd0, 4'b0010, 8'h00, 1'b0, a1);
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("par_drain", 64'(sb.size()), 64'(0));
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
